// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor: one prefix level per stage, LEVELS+1 register stages.
// Valid/ready on both sides; the whole pipe stalls when the output holds a result nobody takes.
module pipelined_prefix_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);
  localparam int LEVELS    = $clog2(WIDTH);
  localparam int LAST_SPAN = 1 << (LEVELS - 1);

  logic                         advance;
  logic [WIDTH-1:0]             yy;
  logic [WIDTH-1:0]             g_in;
  logic [WIDTH-1:0]             p_in;
  logic                         c_in;
  logic [LEVELS-1:0]            v_q;
  logic [LEVELS-1:0]            c_q;
  logic [LEVELS-1:0][WIDTH-1:0] g_q;
  logic [LEVELS-1:0][WIDTH-1:0] p_q;
  logic [LEVELS-1:0][WIDTH-1:0] h_q;
  logic [WIDTH-1:0]             g_fin;
  logic [WIDTH-1:0]             carry;
  logic [WIDTH-1:0]             sum_nx;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Carry-in is folded into bit 0's generate, so every group that reaches bit 0
  // is fully resolved and its propagate can be dropped to zero by the shifts below.
  always_comb begin
    yy      = in_sub ? ~in_y : in_y;
    c_in    = in_sub | in_cin;
    g_in    = in_x & yy;
    p_in    = in_x | yy;
    g_in[0] = g_in[0] | (p_in[0] & c_in);
  end

  always_comb begin
    g_fin  = g_q[LEVELS-1] | (p_q[LEVELS-1] & (g_q[LEVELS-1] << LAST_SPAN));
    carry  = {g_fin[WIDTH-2:0], c_q[LEVELS-1]};
    sum_nx = h_q[LEVELS-1] ^ carry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (advance) begin
      v_q[0] <= in_valid;
      c_q[0] <= c_in;
      g_q[0] <= g_in;
      p_q[0] <= p_in;
      h_q[0] <= in_x ^ yy;
      for (int k = 1; k < LEVELS; k++) begin
        v_q[k] <= v_q[k-1];
        c_q[k] <= c_q[k-1];
        h_q[k] <= h_q[k-1];
        g_q[k] <= g_q[k-1] | (p_q[k-1] & (g_q[k-1] << (1 << (k - 1))));
        p_q[k] <= p_q[k-1] & (p_q[k-1] << (1 << (k - 1)));
      end
      out_valid <= v_q[LEVELS-1];
      out_sum   <= sum_nx;
      out_cout  <= g_fin[WIDTH-1];
      out_ovf   <= carry[WIDTH-1] ^ g_fin[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Bench for pipelined_prefix_adder (WIDTH=16): scoreboard monitor plus one task per scenario.
module tb_pipelined_prefix_adder;
  localparam int WIDTH  = 16;
  localparam int LEVELS = $clog2(WIDTH);
  localparam int LAT    = LEVELS + 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  pipelined_prefix_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          n_in   = 0;
  int          n_out  = 0;
  logic [17:0] sb_q[$];
  logic [17:0] mon_exp;

  // Reference: plain 17-bit addition, overflow from operand/result sign bits.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic cin, input logic sub);
    logic [15:0] yv;
    logic [16:0] s;
    logic        ovf;
    yv  = sub ? ~y : y;
    s   = {1'b0, x} + {1'b0, yv} + {16'd0, (sub ? 1'b1 : cin)};
    ovf = (x[15] == yv[15]) && (s[15] != x[15]);
    return {s[16], ovf, s[15:0]};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got cout=%b ovf=%b sum=%h, required no output", out_cout, out_ovf, out_sum);
        end else begin
          mon_exp = sb_q.pop_front();
          if ({out_cout, out_ovf, out_sum} !== mon_exp)
          begin
            errors++;
            $display("FAIL sb_result: got cout=%b ovf=%b sum=%h, required cout=%b ovf=%b sum=%h",
                     out_cout, out_ovf, out_sum, mon_exp[17], mon_exp[16], mon_exp[15:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(model(in_x, in_y, in_cin, in_sub));
        n_in++;
      end
    end
  end

  // Drive one beat and hold it until accepted; leaves in_valid high.
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic cin, input logic sub);
    int   tries;
    logic acc;
    in_x = x; in_y = y; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    tries = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      tries++;
    end while (!acc && tries < 2000);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 2000 cycles");
    end
  endtask

  task automatic drain(output logic ok);
    int t;
    in_valid = 1'b0;
    t = 0;
    while (sb_q.size() != 0 && t < 1000) begin
      @(posedge clk); #1;
      t++;
    end
    ok = (sb_q.size() == 0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0; in_cin = 1'b0; in_sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    checks++; if (out_sum !== 16'h0000) begin errors++; $display("FAIL rst_out_sum: got %h, required 0000", out_sum); end
    checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL rst_out_cout: got %b, required 0", out_cout); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL rst_out_ovf: got %b, required 0", out_ovf); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid: cycle %0d got %b, required 0", i, out_valid); end
    end
  endtask

  task automatic test_add_latency;
    int          lat;
    logic [17:0] res;
    out_ready = 1'b1;
    in_x = 16'hFFFF; in_y = 16'h0001; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready: got %b, required 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0; res = '0;
    if (out_valid === 1'b1) lat = 1;
    for (int k = 2; k <= LAT + 4; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1 && lat == 0) begin
        lat = k;
        res = {out_cout, out_ovf, out_sum};
      end
    end
    checks++; if (lat != LAT) begin errors++; $display("FAIL add_latency: got %0d cycles, required %0d", lat, LAT); end
    checks++; if (res !== {1'b1, 1'b0, 16'h0000}) begin errors++; $display("FAIL add_ffff_1: got %h, required %h", res, {1'b1, 1'b0, 16'h0000}); end
  endtask

  task automatic test_sub;
    logic [17:0] r[2];
    int          got;
    got = 0; r[0] = '0; r[1] = '0;
    out_ready = 1'b1;
    fork
      begin
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        send(16'h0003, 16'h0005, 1'b0, 1'b1);
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 40 && got < 2; c++) begin
          @(negedge clk);
          if (out_valid && out_ready) begin r[got] = {out_cout, out_ovf, out_sum}; got++; end
        end
      end
    join
    @(posedge clk); #1;
    checks++; if (got != 2) begin errors++; $display("FAIL sub_count: got %0d results, required 2", got); end
    checks++; if (r[0] !== {2'b11, 16'h7FFF}) begin errors++; $display("FAIL sub_8000_1: got %h, required %h", r[0], {2'b11, 16'h7FFF}); end
    checks++; if (r[1] !== {2'b00, 16'hFFFE}) begin errors++; $display("FAIL sub_3_5: got %h, required %h", r[1], {2'b00, 16'hFFFE}); end
  endtask

  task automatic test_back_to_back;
    logic [17:0] expv[8];
    logic [17:0] r[8];
    logic [15:0] xv;
    int          got, first, last;
    logic        ok;
    got = 0; first = -1; last = -1;
    for (int i = 0; i < 8; i++) begin
      xv = 16'(i * 16'h1111);
      expv[i] = model(xv, 16'h0F0F, i[0], 1'b0);
      r[i] = '0;
    end
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) send(16'(i * 16'h1111), 16'h0F0F, i[0], 1'b0);
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 40 && got < 8; c++) begin
          @(negedge clk);
          if (out_valid && out_ready) begin
            if (first < 0) first = c;
            last = c;
            r[got] = {out_cout, out_ovf, out_sum};
            got++;
          end
        end
      end
    join
    drain(ok);
    checks++; if (got != 8) begin errors++; $display("FAIL b2b_count: got %0d, required 8", got); end
    checks++; if (last - first != 7) begin errors++; $display("FAIL b2b_consecutive: got span %0d, required 7", last - first); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (r[i] !== expv[i]) begin errors++; $display("FAIL b2b_result%0d: got %h, required %h", i, r[i], expv[i]); end
    end
  endtask

  task automatic test_backpressure;
    int          start_out, t;
    logic [17:0] snap;
    logic [17:0] exp0;
    logic        ok;
    start_out = n_out;
    exp0 = model(16'h1000, 16'h0234, 1'b0, 1'b0);
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(16'(16'h1000 + i), 16'h0234, 1'b0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        t = 0;
        while (out_valid !== 1'b1 && t < 30) begin @(posedge clk); #1; t++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_fill: out_valid got %b, required 1", out_valid); end
        snap = {out_cout, out_ovf, out_sum};
        checks++; if (snap !== exp0) begin errors++; $display("FAIL bp_head: got %h, required %h", snap, exp0); end
        for (int c = 0; c < 7; c++) begin
          @(posedge clk); #1;
          checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: cycle %0d got %b, required 0", c, in_ready); end
          checks++;
          if (out_valid !== 1'b1 || {out_cout, out_ovf, out_sum} !== exp0) begin
            errors++; $display("FAIL bp_frozen: cycle %0d got v=%b %h, required v=1 %h", c, out_valid, {out_cout, out_ovf, out_sum}, exp0);
          end
        end
        out_ready = 1'b1;
      end
    join
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain: %0d results outstanding, required 0", sb_q.size()); end
    checks++; if (n_out - start_out != 8) begin errors++; $display("FAIL bp_delivered: got %0d, required 8", n_out - start_out); end
  endtask

  task automatic test_reset_flush;
    int start_out;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(16'(16'h0100 * (i + 1)), 16'h0011, 1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b, required 0", out_valid); end
    checks++; if (out_sum !== 16'h0000) begin errors++; $display("FAIL flush_out_sum: got %h, required 0000", out_sum); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b, required 1", in_ready); end
    rst = 1'b0; in_valid = 1'b0;
    start_out = n_out;
    repeat (15) @(posedge clk);
    #1;
    checks++; if (n_out != start_out) begin errors++; $display("FAIL flush_ghost: got %0d results, required 0", n_out - start_out); end
  endtask

  task automatic test_soak;
    logic done;
    logic ok;
    int   start_in, start_out;
    done = 1'b0;
    start_in = n_in; start_out = n_out;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          if ($urandom_range(0, 3) == 0) begin in_valid = 1'b0; @(posedge clk); #1; end
          send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    drain(ok);
    checks++; if (!ok) begin errors++; $display("FAIL soak_drain: %0d outstanding, required 0", sb_q.size()); end
    checks++; if (n_in - start_in != 10000) begin errors++; $display("FAIL soak_accepted: got %0d, required 10000", n_in - start_in); end
    checks++; if (n_out - start_out != 10000) begin errors++; $display("FAIL soak_delivered: got %0d, required 10000", n_out - start_out); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0; in_cin = 1'b0; in_sub = 1'b0;
    test_reset();
    test_add_latency();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_flush();
    test_soak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
